// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared constants and types for the rename register file allocation controller.
// RRF sizing here is also used by the ARF and the renaming table.
package rrf_alloc_ctrl_pkg;

  localparam int unsigned RRF_ENT_NUM = 64;
  localparam int unsigned RRF_ENT_SEL = 6;

  typedef enum logic {
    RRF_ST_RUN,
    RRF_ST_RECOVER
  } rrf_state_e;

  // Population count of a (slot1, slot2) valid pair, 0..2.
  function automatic logic [1:0] pair_cnt(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rrf_ptr_inc.sv
// Modulo-RRF_NUM pointer adder for a 0/1/2 increment.
// RRF_NUM is a power of two, so the wrap is plain truncation to RRF_SEL bits.
module rrf_ptr_inc #(
  parameter int unsigned RRF_SEL = 6
) (
  input  logic [RRF_SEL-1:0] ptr,
  input  logic [1:0]         inc,
  output logic [RRF_SEL-1:0] sum
);

  assign sum = ptr + RRF_SEL'(inc);

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF tag allocator: dual in-order allocation for dispatch, in-order reclaim on commit,
// and a fixed-length recovery window after a pipeline flush.
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int unsigned RRF_NUM     = RRF_ENT_NUM,
  parameter int unsigned RRF_SEL     = RRF_ENT_SEL,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dp_req_1,
  input  logic               i_dp_req_2,
  input  logic               i_dp_hold,
  output logic [RRF_SEL-1:0] o_dp_ptr_1,
  output logic [RRF_SEL-1:0] o_dp_ptr_2,
  output logic               o_dp_grant,
  output logic               o_dp_stall,
  input  logic               i_com_vld_1,
  input  logic               i_com_vld_2,
  output logic [RRF_SEL-1:0] o_com_ptr,
  input  logic               i_flush,
  output logic               o_rt_clr,
  output logic [RRF_SEL:0]   o_free_cnt,
  output logic               o_err
);

  localparam int unsigned CntW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [RRF_SEL:0]   FullCnt    = (RRF_SEL + 1)'(RRF_NUM);
  localparam logic [CntW-1:0]    RecoverMax = CntW'(RECOVER_CYC - 1);

  rrf_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RRF_SEL-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [RRF_SEL-1:0] com_ptr_q, com_ptr_d;
  logic [RRF_SEL:0]   free_cnt_q, free_cnt_d;
  logic               err_q, err_d;
  logic               rt_clr_q;

  logic [1:0]         need, ncom;
  logic [RRF_SEL-1:0] alloc_ptr_inc, com_ptr_inc, ptr_2;
  logic [RRF_SEL:0]   in_use;
  logic [RRF_SEL+1:0] free_sum;
  logic               over_commit, grant;

  assign need = pair_cnt(i_dp_req_1, i_dp_req_2);
  assign ncom = pair_cnt(i_com_vld_1, i_com_vld_2);

  rrf_ptr_inc #(.RRF_SEL(RRF_SEL)) u_alloc_inc (
    .ptr (alloc_ptr_q),
    .inc (need),
    .sum (alloc_ptr_inc)
  );

  rrf_ptr_inc #(.RRF_SEL(RRF_SEL)) u_com_inc (
    .ptr (com_ptr_q),
    .inc (ncom),
    .sum (com_ptr_inc)
  );

  rrf_ptr_inc #(.RRF_SEL(RRF_SEL)) u_slot2_inc (
    .ptr (alloc_ptr_q),
    .inc (2'd1),
    .sum (ptr_2)
  );

  // Registered free count only: a same-cycle commit does not relieve a stall.
  assign o_dp_stall = (state_q == RRF_ST_RECOVER) | i_dp_hold
                    | ((RRF_SEL + 1)'(need) > free_cnt_q);
  assign o_dp_grant = (need != 2'd0) & ~o_dp_stall & ~i_flush;
  assign grant      = o_dp_grant;

  assign in_use      = FullCnt - free_cnt_q;
  assign over_commit = (RRF_SEL + 1)'(ncom) > in_use;
  assign free_sum    = {1'b0, free_cnt_q} + (RRF_SEL + 2)'(ncom)
                     - (grant ? (RRF_SEL + 2)'(need) : '0);

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    com_ptr_d   = com_ptr_inc;
    free_cnt_d  = free_sum[RRF_SEL:0];
    err_d       = err_q | over_commit | (i_dp_req_2 & ~i_dp_req_1)
                | (i_com_vld_2 & ~i_com_vld_1);
    if (i_flush) begin
      // Commits in the flush cycle land first; everything younger is squashed.
      alloc_ptr_d = com_ptr_inc;
      free_cnt_d  = FullCnt;
    end else begin
      if (grant) alloc_ptr_d = alloc_ptr_inc;
      if (over_commit) free_cnt_d = FullCnt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = RRF_ST_RECOVER;
      cnt_d   = RecoverMax;
    end else begin
      unique case (state_q)
        RRF_ST_RUN: ;
        RRF_ST_RECOVER: begin
          if (cnt_q == '0) state_d = RRF_ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = RRF_ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RRF_ST_RUN;
      cnt_q       <= '0;
      alloc_ptr_q <= '0;
      com_ptr_q   <= '0;
      free_cnt_q  <= FullCnt;
      err_q       <= 1'b0;
      rt_clr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alloc_ptr_q <= alloc_ptr_d;
      com_ptr_q   <= com_ptr_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
      rt_clr_q    <= i_flush;
    end
  end

  assign o_dp_ptr_1 = alloc_ptr_q;
  assign o_dp_ptr_2 = ptr_2;
  assign o_com_ptr  = com_ptr_q;
  assign o_free_cnt = free_cnt_q;
  assign o_err      = err_q;
  assign o_rt_clr   = rt_clr_q;

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Directed bench for rrf_alloc_ctrl with hand-computed expectations.
module tb_rrf_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_dp_req_1, i_dp_req_2, i_dp_hold;
  logic [5:0] o_dp_ptr_1, o_dp_ptr_2, o_com_ptr;
  logic       o_dp_grant, o_dp_stall;
  logic       i_com_vld_1, i_com_vld_2, i_flush;
  logic       o_rt_clr, o_err;
  logic [6:0] o_free_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6), .RECOVER_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_dp_req_1  (i_dp_req_1),
    .i_dp_req_2  (i_dp_req_2),
    .i_dp_hold   (i_dp_hold),
    .o_dp_ptr_1  (o_dp_ptr_1),
    .o_dp_ptr_2  (o_dp_ptr_2),
    .o_dp_grant  (o_dp_grant),
    .o_dp_stall  (o_dp_stall),
    .i_com_vld_1 (i_com_vld_1),
    .i_com_vld_2 (i_com_vld_2),
    .o_com_ptr   (o_com_ptr),
    .i_flush     (i_flush),
    .o_rt_clr    (o_rt_clr),
    .o_free_cnt  (o_free_cnt),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Drive: req1, req2, hold, com1, com2, flush. Settles before combinational checks.
  task automatic drive(input logic r1, input logic r2, input logic h,
                       input logic c1, input logic c2, input logic f);
    i_dp_req_1  = r1;
    i_dp_req_2  = r2;
    i_dp_hold   = h;
    i_com_vld_1 = c1;
    i_com_vld_2 = c2;
    i_flush     = f;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    check_val("rst_free", o_free_cnt, 64);
    check_val("rst_ptr1", o_dp_ptr_1, 0);
    check_val("rst_ptr2", o_dp_ptr_2, 1);
    check_val("rst_com", o_com_ptr, 0);
    check_val("rst_err", o_err, 0);
    check_val("rst_rtclr", o_rt_clr, 0);

    // Three dual allocations.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      check_val("dual_ptr1", o_dp_ptr_1, 2 * i);
      check_val("dual_ptr2", o_dp_ptr_2, 2 * i + 1);
      check_val("dual_grant", o_dp_grant, 1);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    check_val("dual_free", o_free_cnt, 58);
    check_val("dual_com", o_com_ptr, 0);

    // Fill to 63 allocated: 28 pairs plus one single.
    for (int i = 0; i < 28; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check_val("fill_free", o_free_cnt, 1);
    check_val("fill_ptr1", o_dp_ptr_1, 63);

    // Pair at free_cnt=1 stalls whole; same-cycle commit does not relieve it.
    drive(1, 1, 0, 1, 0, 0);
    check_val("low_stall", o_dp_stall, 1);
    check_val("low_grant", o_dp_grant, 0);
    cyc();
    drive(1, 1, 0, 0, 0, 0);
    check_val("relief_free", o_free_cnt, 2);
    check_val("relief_grant", o_dp_grant, 1);
    check_val("wrap_ptr1", o_dp_ptr_1, 63);
    check_val("wrap_ptr2", o_dp_ptr_2, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    check_val("wrap_next", o_dp_ptr_1, 1);
    check_val("full_free", o_free_cnt, 0);
    check_val("full_stall", o_dp_stall, 1);

    // Retire 10 to reach free_cnt=10.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      cyc();
    end
    drive(1, 1, 0, 1, 1, 0);
    check_val("sim_free0", o_free_cnt, 10);
    check_val("sim_com0", o_com_ptr, 11);
    check_val("sim_grant", o_dp_grant, 1);
    cyc();
    drive(1, 1, 1, 0, 0, 0);
    check_val("sim_free", o_free_cnt, 10);
    check_val("sim_ptr1", o_dp_ptr_1, 3);
    check_val("sim_com", o_com_ptr, 13);
    check_val("hold_grant", o_dp_grant, 0);
    check_val("hold_stall", o_dp_stall, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check_val("hold_ptr1", o_dp_ptr_1, 3);
    check_val("hold_free", o_free_cnt, 10);
    check_val("clean_err", o_err, 0);

    // Flush with 10 in flight, com_ptr=4.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      cyc();
    end
    drive(1, 0, 0, 1, 0, 1);
    check_val("pre_flush_com", o_com_ptr, 4);
    check_val("pre_flush_free", o_free_cnt, 54);
    check_val("flush_grant", o_dp_grant, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    check_val("flush_ptr1", o_dp_ptr_1, 5);
    check_val("flush_com", o_com_ptr, 5);
    check_val("flush_free", o_free_cnt, 64);
    check_val("flush_rtclr", o_rt_clr, 1);
    check_val("rec1_stall", o_dp_stall, 1);
    cyc();
    check_val("rec2_rtclr", o_rt_clr, 0);
    check_val("rec2_stall", o_dp_stall, 1);
    check_val("rec2_grant", o_dp_grant, 0);
    cyc();
    check_val("run_stall", o_dp_stall, 0);
    check_val("run_grant", o_dp_grant, 1);
    check_val("run_ptr1", o_dp_ptr_1, 5);
    cyc();

    // Flush, re-flush during RECOVER, then reset mid-RECOVER.
    drive(0, 0, 0, 0, 0, 1);
    cyc();
    check_val("rf_rtclr1", o_rt_clr, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check_val("rf_rtclr2", o_rt_clr, 1);
    check_val("rf_stall", o_dp_stall, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check_val("mrst_rtclr", o_rt_clr, 0);
    check_val("mrst_stall", o_dp_stall, 0);
    check_val("mrst_ptr1", o_dp_ptr_1, 0);

    // Over-commit at empty: sticky error, free count clamped.
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check_val("oc_err", o_err, 1);
    check_val("oc_free", o_free_cnt, 64);
    check_val("oc_com", o_com_ptr, 1);
    cyc();
    cyc();
    check_val("oc_sticky", o_err, 1);

    // req_2 alone: flagged but still processed as one entry.
    do_reset();
    check_val("r2_err0", o_err, 0);
    drive(0, 1, 0, 0, 0, 0);
    check_val("r2_grant", o_dp_grant, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    check_val("r2_err", o_err, 1);
    check_val("r2_ptr1", o_dp_ptr_1, 1);
    check_val("r2_free", o_free_cnt, 63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
